mul_rep_add: RTL and testbench
==============================

MUL_REP_ADD -- requirements
Module: mul_rep_add

Interface
REQ-001 Parameter: WIDTH, 8, operand width; product width is 2*WIDTH (16 at default).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  multiplicand (addend); unsigned.
REQ-006 Port: b  input  WIDTH  multiplier (loop count); unsigned.
REQ-007 Port: busy  output  1  high whenever state is not IDLE.
REQ-008 Port: done  output  1  registered one-cycle pulse; product valid.
REQ-009 Port: product  output  2*WIDTH  registered result a*b.

Function
REQ-010 Block SHALL compute a*b by repeated addition: accumulator += latched addend, once per cycle, loop-count times.
REQ-011 FSM states SHALL be IDLE, RUN, DONE only; encodings from the shared package.
REQ-012 IDLE and start=1 at edge: latch addend, load loop count, clear accumulator, go to RUN.
REQ-013 RUN with count != 0: accumulator <= accumulator + addend (2*WIDTH bits, addend zero-extended), count <= count - 1, stay in RUN.
REQ-014 RUN with count == 0: product <= accumulator, go to DONE; no addition that cycle.
REQ-015 DONE: done=1 for exactly that cycle, then unconditionally go to IDLE.
REQ-016 Latency: start sampled in cycle 0 -> done high in cycle N+2, N = loop count; b=0 gives done in cycle 2, product 0.
REQ-017 Accumulator SHALL never overflow: max (2^WIDTH-1)^2 fits 2*WIDTH bits; no carry-out kept.
REQ-018 start while busy SHALL be ignored, no queuing; a/b changes after acceptance SHALL not affect the result.
REQ-019 start asserted in the DONE cycle SHALL be ignored; a new start is accepted no earlier than the following IDLE cycle.
REQ-020 product SHALL hold its last value from DONE until the next DONE; it does not change during RUN.

Reset
REQ-021 rst=1 at a rising edge SHALL force IDLE, product=0, done=0, accumulator=0, count=0, regardless of state.
REQ-022 rst mid-RUN SHALL abort the operation; no done pulse is produced for it.
REQ-023 rst has priority over start in the same cycle.

Configuration
REQ-024 Macro MUL_REP_ADD_SWAP_EN defined: at acceptance, the smaller of a,b SHALL become the loop count and the larger the addend (ties: b is count); latency is min(a,b)+2.
REQ-025 Macro undefined: b is always the loop count, a always the addend; latency is b+2; no comparator is synthesised.

Structure
REQ-026 Shared package SHALL hold the FSM state typedef/encodings (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-027 The accumulate adder SHALL be a separate 2*WIDTH-bit combinational adder sub-module, adder_2w, instantiated once; the FSM/registers stay in mul_rep_add.

Verification
REQ-028 a=3, b=5, start pulse in cycle 0 -> busy cycles 1-2+5, done in cycle 7, product=15.
REQ-029 a=255, b=255 -> done in cycle 257 (swap off or on), product=65025, no overflow.
REQ-030 a=200, b=0 -> done in cycle 2, product=0; with SWAP_EN a=200, b=3 -> done in cycle 5, product=600.
REQ-031 a=4, b=6 accepted; at cycle 3 start=1 with a=9, b=9 -> ignored, done in cycle 8, product=24; start in the DONE cycle also ignored.
REQ-032 a=10, b=10 accepted; rst=1 in cycle 4 -> cycle 5 busy=0, product=0, no done pulse; subsequent a=2, b=2 -> product=4.

Source files
------------

// File: rtl/mul_rep_add_pkg.sv
// Shared definitions for the repeated-addition multiplier: FSM encodings and default operand width.
package mul_rep_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_rep_add_adder_2w.sv
// Combinational accumulate adder used by mul_rep_add; carry-out is discarded because
// the accumulator can never exceed (2^WIDTH-1)^2.
module adder_2w #(
    parameter int W = 16
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] sum
);

    assign sum = x + y;

endmodule

// File: rtl/mul_rep_add.sv
// Unsigned multiplier by repeated addition: one addend accumulation per RUN cycle.
// Optional macro MUL_REP_ADD_SWAP_EN makes the smaller operand the loop count.
module mul_rep_add
    import mul_rep_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    state_t               state_reg, state_next;
    logic [WIDTH-1:0]     count_reg;
    logic [WIDTH-1:0]     addend_reg;
    logic [2*WIDTH-1:0]   acc_reg;
    logic [2*WIDTH-1:0]   product_reg;
    logic                 done_reg;
    logic [2*WIDTH-1:0]   sum;
    logic [WIDTH-1:0]     load_count;
    logic [WIDTH-1:0]     load_addend;

`ifdef MUL_REP_ADD_SWAP_EN
    // Fewer iterations when the smaller operand drives the loop; ties keep b as count.
    always_comb begin
        load_count  = b;
        load_addend = a;
        if (a < b) begin
            load_count  = a;
            load_addend = b;
        end
    end
`else
    assign load_count  = b;
    assign load_addend = a;
`endif

    adder_2w #(
        .W (2*WIDTH)
    ) u_adder (
        .x   (acc_reg),
        .y   ({{WIDTH{1'b0}}, addend_reg}),
        .sum (sum)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (count_reg == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            addend_reg  <= '0;
            acc_reg     <= '0;
            product_reg <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        addend_reg <= load_addend;
                        count_reg  <= load_count;
                        acc_reg    <= '0;
                    end
                end
                RUN: begin
                    if (count_reg != '0) begin
                        acc_reg   <= sum;
                        count_reg <= count_reg - 1'b1;
                    end else begin
                        product_reg <= acc_reg;
                        done_reg    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state_reg != IDLE);
    assign done    = done_reg;
    assign product = product_reg;

endmodule

// File: tb/tb_mul_rep_add.sv
// Directed self-checking bench for mul_rep_add; cycle 0 is the cycle in which start is sampled.
module tb_mul_rep_add;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int          checks;
    int          failures;
    logic [15:0] last_prod;
    int          cyc;

    mul_rep_add #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end else begin
            $display("ok   %s value=%0d", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Drives one start in cycle 0, then waits (bounded) for done and checks latency and result.
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input int lat, input logic [15:0] prod);
        @(posedge clk);
        #1;
        a = av;
        b = bv;
        start = 1'b1;
        cyc = 0;
        step();
        start = 1'b0;
        check_val({tag, "_busy_c1"}, {31'd0, busy}, 32'd1);
        check_val({tag, "_hold_c1"}, {16'd0, product}, {16'd0, last_prod});
        while (!done && cyc < lat + 5) step();
        check_val({tag, "_latency"}, cyc, lat);
        check_val({tag, "_product"}, {16'd0, product}, {16'd0, prod});
        last_prod = prod;
        step();
        check_val({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check_val({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        last_prod = 16'd0;
        cyc       = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = 8'd0;
        b     = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("reset_busy", {31'd0, busy}, 32'd0);
        check_val("reset_done", {31'd0, done}, 32'd0);
        check_val("reset_product", {16'd0, product}, 32'd0);

        run_op("m3x5", 8'd3, 8'd5, 7, 16'd15);
        run_op("m255x255", 8'd255, 8'd255, 257, 16'd65025);
        run_op("m200x0", 8'd200, 8'd0, 2, 16'd0);
        run_op("m200x3", 8'd200, 8'd3, 5, 16'd600);
`ifdef MUL_REP_ADD_SWAP_EN
        run_op("m3x200", 8'd3, 8'd200, 5, 16'd600);
`else
        run_op("m3x200", 8'd3, 8'd200, 202, 16'd600);
`endif
        run_op("m7x7", 8'd7, 8'd7, 9, 16'd49);

        // Start while busy and in the DONE cycle must both be ignored.
        @(posedge clk);
        #1;
        a = 8'd4;
        b = 8'd6;
        start = 1'b1;
        cyc = 0;
        step();
        start = 1'b0;
        while (cyc < 3) step();
        a = 8'd9;
        b = 8'd9;
        start = 1'b1;
        step();
        start = 1'b0;
        while (!done && cyc < 20) step();
        check_val("busy_start_latency", cyc, 8);
        check_val("busy_start_product", {16'd0, product}, 32'd24);
        last_prod = 16'd24;
        start = 1'b1;
        step();
        start = 1'b0;
        check_val("done_start_busy_c9", {31'd0, busy}, 32'd0);
        step();
        check_val("done_start_busy_c10", {31'd0, busy}, 32'd0);
        check_val("done_start_product", {16'd0, product}, 32'd24);

        // Reset mid-RUN aborts without a done pulse.
        @(posedge clk);
        #1;
        a = 8'd10;
        b = 8'd10;
        start = 1'b1;
        cyc = 0;
        step();
        start = 1'b0;
        while (cyc < 4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("abort_busy", {31'd0, busy}, 32'd0);
        check_val("abort_product", {16'd0, product}, 32'd0);
        check_val("abort_done", {31'd0, done}, 32'd0);
        last_prod = 16'd0;
        begin
            int seen;
            seen = 0;
            repeat (15) begin
                step();
                if (done || busy) seen++;
            end
            check_val("abort_no_done", seen, 0);
        end

        // Reset wins over a simultaneous start.
        @(posedge clk);
        #1;
        a = 8'd5;
        b = 8'd5;
        start = 1'b1;
        rst = 1'b1;
        step();
        start = 1'b0;
        rst = 1'b0;
        check_val("rst_prio_busy", {31'd0, busy}, 32'd0);

        run_op("m2x2", 8'd2, 8'd2, 4, 16'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
